// File: rtl/plic_src_pkg.sv
// Shared types and helpers for the PLIC source conditioner.
package plic_src_pkg;

   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      QUAL_HI = 2'd1,
      ST_HI   = 2'd2,
      QUAL_LO = 2'd3
   } filt_state_t;

   // Debounce counter width able to hold 0..filter_cnt.
   function automatic int unsigned cnt_bits(input int unsigned filter_cnt);
      return $clog2(filter_cnt + 1);
   endfunction

endpackage

// File: rtl/plic_src_filter.sv
// Per-source debounce FSM: a new level must hold for FILTER_CNT sample ticks
// before it is accepted; filt_en = 0 bypasses the filter.
module plic_src_filter
   import plic_src_pkg::*;
#(
   parameter int unsigned FILTER_CNT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic sync,
   input  logic filt_en,
   output logic src,
   output logic src_rise
);

   localparam int unsigned    CW       = cnt_bits(FILTER_CNT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CNT - 1);

   filt_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          src_q, src_d;
   logic          rise_q, rise_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LO;
         cnt_q   <= '0;
         src_q   <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         rise_q  <= rise_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!filt_en) begin
         // Track the synchronised level so re-enabling never creates an edge.
         state_d = sync ? ST_HI : ST_LO;
         cnt_d   = '0;
      end else if (tick) begin
         unique case (state_q)
            ST_LO: begin
               if (sync) begin
                  if (FILTER_CNT == 1) begin
                     state_d = ST_HI;
                     cnt_d   = '0;
                  end else begin
                     state_d = QUAL_HI;
                     cnt_d   = CW'(1);
                  end
               end
            end
            QUAL_HI: begin
               if (!sync) begin
                  state_d = ST_LO;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_HI;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_HI: begin
               if (!sync) begin
                  if (FILTER_CNT == 1) begin
                     state_d = ST_LO;
                     cnt_d   = '0;
                  end else begin
                     state_d = QUAL_LO;
                     cnt_d   = CW'(1);
                  end
               end
            end
            QUAL_LO: begin
               if (sync) begin
                  state_d = ST_HI;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = ST_LO;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = ST_LO;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      src_d  = (state_q == ST_HI) || (state_q == QUAL_LO);
      rise_d = src_d & ~src_q;
   end

   assign src      = src_q;
   assign src_rise = rise_q;

endmodule

// File: rtl/plic_src_conditioner.sv
// PLIC source front-end: synchroniser, shared prescaler and per-source debounce.
// Optional PLIC_SRC_POLARITY_EN adds src_pol to make individual lines active-low.
module plic_src_conditioner
   import plic_src_pkg::*;
#(
   parameter int unsigned SOURCES     = 64,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_CNT  = 4,
   parameter int unsigned PRESCALE    = 1
) (
   input  logic               HCLK,
   input  logic               HRESET,
   input  logic [SOURCES-1:0] src_async,
   input  logic [SOURCES-1:0] filt_en,
`ifdef PLIC_SRC_POLARITY_EN
   input  logic [SOURCES-1:0] src_pol,
`endif
   output logic [SOURCES-1:0] src,
   output logic [SOURCES-1:0] src_rise
);

   localparam int unsigned   PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [SOURCES-1:0] pol_in;
   logic [SOURCES-1:0] sync_q [SYNC_STAGES];
   logic [SOURCES-1:0] sync_d [SYNC_STAGES];
   logic [PW-1:0]      presc_q, presc_d;
   logic               tick;

`ifdef PLIC_SRC_POLARITY_EN
   assign pol_in = src_async ^ src_pol;
`else
   assign pol_in = src_async;
`endif

   always_comb begin
      sync_d[0] = pol_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   // Shared sample-tick prescaler; with PRESCALE = 1 the tick is constant.
   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         presc_q <= '0;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_d[k];
         end
         presc_q <= presc_d;
      end
   end

   for (genvar i = 0; i < SOURCES; i++) begin : g_src
      plic_src_filter #(
         .FILTER_CNT (FILTER_CNT)
      ) u_filter (
         .clk      (HCLK),
         .rst      (HRESET),
         .tick     (tick),
         .sync     (sync_q[SYNC_STAGES-1][i]),
         .filt_en  (filt_en[i]),
         .src      (src[i]),
         .src_rise (src_rise[i])
      );
   end

endmodule

// File: tb/tb_plic_src_conditioner.sv
// Randomised bench for plic_src_conditioner against a run-length debounce model;
// a second instance runs with PRESCALE = 4.
module tb_plic_src_conditioner;

   localparam int P1 = 4;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [63:0] in_v, fe_v, pol_v;
   logic [63:0] src0, rise0;
   logic [7:0]  src1, rise1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 HCLK = ~HCLK;

   plic_src_conditioner dut0 (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .src_async (in_v),
      .filt_en   (fe_v),
`ifdef PLIC_SRC_POLARITY_EN
      .src_pol   (pol_v),
`endif
      .src       (src0),
      .src_rise  (rise0)
   );

   plic_src_conditioner #(
      .SOURCES     (8),
      .SYNC_STAGES (2),
      .FILTER_CNT  (4),
      .PRESCALE    (P1)
   ) dut1 (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .src_async (in_v[7:0]),
      .filt_en   (fe_v[7:0]),
`ifdef PLIC_SRC_POLARITY_EN
      .src_pol   (pol_v[7:0]),
`endif
      .src       (src1),
      .src_rise  (rise1)
   );

   // Behavioural model: inputs are delayed SYNC_STAGES cycles; a filtered level
   // flips once the last FILTER_CNT tick samples all show the opposite level;
   // the output register adds one more cycle.
   logic [63:0] m_s   [2][4];
   logic [63:0] m_l   [2];
   logic [63:0] m_src [2];
   logic [63:0] m_rise[2];
   logic [7:0]  m_h   [2][64];
   int          m_pc  [2];

   function automatic int nsrc(input int d); return (d == 0) ? 64 : 8; endfunction
   function automatic int ss(input int d);   return 2; endfunction
   function automatic int fc(input int d);   return 4; endfunction
   function automatic int ps(input int d);   return (d == 0) ? 1 : P1; endfunction

   task automatic model_step(input int d);
      logic        tk;
      logic [63:0] sy;
      logic [7:0]  mask, h;
      mask = 8'((1 << fc(d)) - 1);
      if (HRESET) begin
         for (int k = 0; k < 4; k++) m_s[d][k] = '0;
         for (int i = 0; i < 64; i++) m_h[d][i] = '0;
         m_l[d] = '0; m_src[d] = '0; m_rise[d] = '0; m_pc[d] = 0;
         return;
      end
      tk = (m_pc[d] == ps(d) - 1);
      sy = m_s[d][ss(d)-1];
      m_rise[d] = m_l[d] & ~m_src[d];
      m_src[d]  = m_l[d];
      for (int i = 0; i < nsrc(d); i++) begin
         if (!fe_v[i]) begin
            m_l[d][i] = sy[i];
            m_h[d][i] = sy[i] ? 8'hFF : 8'h00;
         end else if (tk) begin
            h = {m_h[d][i][6:0], sy[i]};
            m_h[d][i] = h;
            if (m_l[d][i] ? ((h & mask) == 8'h00) : ((h & mask) == mask))
               m_l[d][i] = ~m_l[d][i];
         end
      end
      for (int k = ss(d) - 1; k > 0; k--) m_s[d][k] = m_s[d][k-1];
      m_s[d][0] = in_v ^ pol_v;
      m_pc[d] = tk ? 0 : m_pc[d] + 1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // One clock: advance the model at the edge, compare both instances after it.
   task automatic step_cycle();
      @(posedge HCLK);
      model_step(0);
      model_step(1);
      #1;
      cyc++;
      chk("src0",  src0,        m_src[0]);
      chk("rise0", rise0,       m_rise[0]);
      chk("src1",  64'(src1),   64'(m_src[1][7:0]));
      chk("rise1", 64'(rise1),  64'(m_rise[1][7:0]));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step_cycle();
   endtask

   initial begin
      int          first, hi, rises, rise_at;
      logic        flag;
      logic [9:0]  pat;
      logic [63:0] fm;

      HRESET = 1'b1;
      in_v   = '1;
      fe_v   = '1;
      pol_v  = '0;

      // Reset with all lines high, then one synchronous qualified rise.
      for (int k = 0; k < 3; k++) begin
         step_cycle();
         chk("rst_src",  src0,  64'd0);
         chk("rst_rise", rise0, 64'd0);
      end
      HRESET = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step_cycle();
         if (k == 5) chk("rel_src_c5", src0, 64'd0);
         if (k == 6) begin
            chk("rel_src_c6",  src0,  '1);
            chk("rel_rise_c6", rise0, '1);
         end
         if (k == 7) chk("rel_rise_c7", rise0, 64'd0);
      end

      // Glitch rejection, high then low.
      in_v = '0;
      idle(12);
      flag = 1'b0;
      in_v[5] = 1'b1;
      for (int k = 0; k < 15; k++) begin
         step_cycle();
         if (k == 2) in_v[5] = 1'b0;
         flag |= src0[5] | rise0[5];
      end
      chk("glitch_hi", 64'(flag), 64'd0);
      in_v[5] = 1'b1;
      idle(12);
      chk("src5_hi", 64'(src0[5]), 64'd1);
      flag = 1'b0;
      in_v[5] = 1'b0;
      for (int k = 0; k < 15; k++) begin
         step_cycle();
         if (k == 2) in_v[5] = 1'b1;
         flag |= ~src0[5];
      end
      chk("glitch_lo", 64'(flag), 64'd0);
      in_v[5] = 1'b0;
      idle(12);

      // 10-cycle pulse on line 7.
      first = -1; hi = 0; rises = 0; rise_at = -1;
      in_v[7] = 1'b1;
      for (int k = 0; k < 30; k++) begin
         step_cycle();
         if (k == 9) in_v[7] = 1'b0;
         if (src0[7]) begin
            if (first < 0) first = k;
            hi++;
         end
         if (rise0[7]) begin rises++; rise_at = k; end
      end
      chk("p7_first",   64'(first),   64'd6);
      chk("p7_width",   64'(hi),      64'd10);
      chk("p7_rises",   64'(rises),   64'd1);
      chk("p7_rise_at", 64'(rise_at), 64'd6);

      // Bypass on line 3: 1-cycle pulse, then filt_en toggling on a stable line.
      fe_v[3] = 1'b0;
      idle(4);
      pat = '0; rises = 0;
      in_v[3] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step_cycle();
         if (k == 0) in_v[3] = 1'b0;
         pat[k] = src0[3];
         if (rise0[3]) rises++;
      end
      chk("byp_pat",   64'(pat),   64'h8);
      chk("byp_rises", 64'(rises), 64'd1);
      in_v[3] = 1'b1;
      idle(8);
      flag = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0) fe_v[3] = ~fe_v[3];
         step_cycle();
         flag |= ~src0[3] | rise0[3];
      end
      chk("byp_toggle", 64'(flag), 64'd0);
      in_v[3] = 1'b0;
      idle(8);
      fe_v[3] = 1'b1;
      idle(4);

      // Prescaled instance: 3 ticks rejected, 5 ticks accepted.
      flag = 1'b0;
      in_v[0] = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step_cycle();
         if (k == 11) in_v[0] = 1'b0;
         flag |= src1[0];
      end
      chk("presc_rej", 64'(flag), 64'd0);
      rise_at = -1;
      in_v[0] = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step_cycle();
         if (k == 19) in_v[0] = 1'b0;
         if (rise1[0] && rise_at < 0) rise_at = k;
      end
      chk("presc_acc", 64'((rise_at >= 0) && (rise_at <= 18)), 64'd1);
      idle(10);

      // All lines toggle together, alternate bypass/filtered.
      fe_v = 64'hAAAA_AAAA_AAAA_AAAA;
      idle(4);
      in_v = '1;
      for (int k = 0; k < 8; k++) begin
         step_cycle();
         if (k == 2) chk("all_c2", src0, 64'd0);
         if (k == 3) begin
            chk("all_c3",      src0,  ~fe_v);
            chk("all_rise_c3", rise0, ~fe_v);
         end
         if (k == 5) chk("all_c5", src0, ~fe_v);
         if (k == 6) begin
            chk("all_c6",      src0,  '1);
            chk("all_rise_c6", rise0, fe_v);
         end
      end
`ifdef PLIC_SRC_POLARITY_EN
      in_v     = '0;
      pol_v[0] = 1'b1;
      idle(12);
      chk("pol0", 64'(src0[0]), 64'd1);
      pol_v[0] = 1'b0;
`endif
      in_v = '0;
      fe_v = '1;
      idle(12);

      // Random stimulus with varying toggle density and occasional filt_en changes.
      for (int n = 0; n < 3000; n++) begin
         if (n % 150 == 0) fe_v = {$urandom, $urandom} | {$urandom, $urandom};
         fm = {$urandom, $urandom};
         case ((n / 500) % 3)
            0: ;
            1: fm &= {$urandom, $urandom} & {$urandom, $urandom};
            default: for (int j = 0; j < 4; j++) fm &= {$urandom, $urandom};
         endcase
         in_v ^= fm;
         step_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
